// File: rtl/sp_mac_operand_feeder.sv
// Operand feeder for a systolic MAC chain: buffers int4/int8 operand beats, issues them on pulse
// strobes gated by hold, then issues ARRAY_DEPTH zero beats to drain the array before done.
module sp_mac_operand_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ARRAY_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_a1,
  input  logic [3:0] s_a2,
  input  logic [7:0] s_b1,
  input  logic [7:0] s_b2,
  input  logic       hold,
  output logic       pulse,
  output logic [3:0] out_a1,
  output logic [3:0] out_a2,
  output logic [7:0] out_b1,
  output logic [7:0] out_b2,
  output logic [8:0] out_mix,
  output logic       busy,
  output logic       done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(ARRAY_DEPTH + 1);
  localparam int EW = 33;  // {a1, a2, b1, b2, mix}

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      acc_cnt_q, acc_cnt_d;
  logic [7:0]      iss_cnt_q, iss_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [EW-1:0]   out_q, out_d;
  logic            pulse_q, pulse_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [8:0]      wr_mix;
  logic [EW-1:0]   wr_entry;

  assign fifo_full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign s_ready    = (state_q == FEED) && !fifo_full && (acc_cnt_q < len_q);
  assign push       = s_valid && s_ready;
  assign pop        = (state_q == FEED) && !fifo_empty && !hold;
  assign wr_mix     = {s_b1[7], s_b1} + {s_b2[7], s_b2};
  assign wr_entry   = {s_a1, s_a2, s_b1, s_b2, wr_mix};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    iss_cnt_d   = iss_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    mem_d       = mem_q;
    out_d       = out_q;
    pulse_d     = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      acc_cnt_d       = acc_cnt_q + 8'd1;
    end
    if (pop) begin
      out_d     = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
      pulse_d   = 1'b1;
      iss_cnt_d = iss_cnt_q + 8'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = len;
          acc_cnt_d   = '0;
          iss_cnt_d   = '0;
          flush_cnt_d = '0;
          state_d     = (len != 8'd0) ? FEED : DONE;
        end
      end
      FEED: begin
        if (pop && ((iss_cnt_q + 8'd1) == len_q)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Extra cycle after the final zero beat so done trails the last pulse.
        if (flush_cnt_q == FW'(ARRAY_DEPTH)) begin
          state_d = DONE;
        end else if (!hold) begin
          out_d       = '0;
          pulse_d     = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      iss_cnt_q   <= '0;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_q       <= out_d;
      pulse_q     <= pulse_d;
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {out_a1, out_a2, out_b1, out_b2, out_mix} = out_q;
  assign pulse = pulse_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_sp_mac_operand_feeder.sv
// Bench for sp_mac_operand_feeder: cycle vector table plus directed multi-cycle sequences.
module tb_sp_mac_operand_feeder;

  logic       clk = 1'b0;
  logic       reset, start, s_valid, s_ready, hold, pulse, busy, done;
  logic [7:0] len, s_b1, s_b2, out_b1, out_b2;
  logic [3:0] s_a1, s_a2, out_a1, out_a2;
  logic [8:0] out_mix;

  sp_mac_operand_feeder #(.FIFO_DEPTH(4), .ARRAY_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a1(s_a1), .s_a2(s_a2), .s_b1(s_b1), .s_b2(s_b2),
    .hold(hold), .pulse(pulse),
    .out_a1(out_a1), .out_a2(out_a2), .out_b1(out_b1), .out_b2(out_b2), .out_mix(out_mix),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef logic [32:0] ent_t;

  typedef struct packed {
    logic       start;
    logic [7:0] len;
    logic       vld;
    logic [3:0] a1, a2;
    logic [7:0] b1, b2;
    logic       hold;
    logic [3:0] e_flags;  // {pulse, s_ready, busy, done}
    ent_t       e_out;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  ent_t pq[$];
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (pulse) pq.push_back({out_a1, out_a2, out_b1, out_b2, out_mix});
    if (done)  done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t v(input logic st, input logic [7:0] ln, input logic vl,
                             input logic [3:0] a1, input logic [3:0] a2,
                             input logic [7:0] b1, input logic [7:0] b2, input logic hd,
                             input logic [3:0] flags, input ent_t eo);
    vec_t r;
    r = '{st, ln, vl, a1, a2, b1, b2, hd, flags, eo};
    return r;
  endfunction

  // Independent operand model: mix is the signed integer sum of b1 and b2.
  function automatic ent_t beat(input int k);
    logic [3:0] a1, a2;
    logic [7:0] b1, b2;
    int sb1, sb2;
    a1 = 4'(k);
    a2 = 4'(-k);
    b1 = 8'(k * 30 - 100);
    b2 = 8'(17 * k + 3);
    sb1 = (b1 > 8'd127) ? int'(b1) - 256 : int'(b1);
    sb2 = (b2 > 8'd127) ? int'(b2) - 256 : int'(b2);
    return {a1, a2, b1, b2, 9'(sb1 + sb2)};
  endfunction

  task automatic drive_beat(input int k);
    ent_t e;
    e = beat(k);
    {s_a1, s_a2, s_b1, s_b2} = e[32:9];
  endtask

  function automatic logic [36:0] obs();
    return {pulse, s_ready, busy, done, out_a1, out_a2, out_b1, out_b2, out_mix};
  endfunction

  vec_t vecs[22];

  initial begin
    int   idx, leak, n;
    logic fire;

    // flags = {pulse, s_ready, busy, done}
    vecs[0]  = v(1, 2, 0, 0, 0, 0, 0, 0, 4'b0110, '0);
    vecs[1]  = v(0, 0, 1, 4'h1, 4'hF, 8'h05, 8'hFD, 0, 4'b0110, '0);
    vecs[2]  = v(0, 0, 1, 4'h2, 4'h3, 8'h7F, 8'h7F, 0, 4'b1010, {4'h1, 4'hF, 8'h05, 8'hFD, 9'h002});
    vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, {4'h2, 4'h3, 8'h7F, 8'h7F, 9'h0FE});
    vecs[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, '0);
    vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, '0);
    vecs[10] = v(1, 1, 0, 0, 0, 0, 0, 0, 4'b0110, '0);
    vecs[11] = v(0, 0, 1, 4'h8, 4'h7, 8'h80, 8'h80, 0, 4'b0010, '0);
    vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, {4'h8, 4'h7, 8'h80, 8'h80, 9'h100});
    vecs[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, '0);
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, '0);
    vecs[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, '0);
    vecs[19] = v(1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, '0);
    vecs[20] = v(1, 2, 0, 0, 0, 0, 0, 0, 4'b0000, '0);
    vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, '0);

    reset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; hold = 1'b0;
    s_a1 = '0; s_a2 = '0; s_b1 = '0; s_b2 = '0;
    #12;
    chk("reset_state", 64'(obs()), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Cycle-exact table: basic len=2, negative extremes, zero length, start during DONE.
    for (int i = 0; i < 22; i++) begin
      start = vecs[i].start; len = vecs[i].len; s_valid = vecs[i].vld; hold = vecs[i].hold;
      s_a1 = vecs[i].a1; s_a2 = vecs[i].a2; s_b1 = vecs[i].b1; s_b2 = vecs[i].b2;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'(obs()), 64'({vecs[i].e_flags, vecs[i].e_out}));
    end
    start = 1'b0; len = '0; s_valid = 1'b0;

    // Backpressure: hold for 10 cycles while the source keeps offering beats.
    pq.delete(); done_cnt = 0;
    hold = 1'b1; start = 1'b1; len = 8'd8;
    @(posedge clk); #1;
    start = 1'b0; len = '0; idx = 0; s_valid = 1'b1; drive_beat(0);
    repeat (10) begin
      fire = s_ready;
      @(posedge clk); #1;
      if (fire) begin idx++; drive_beat(idx); end
    end
    chk("bp_accepts_under_hold", 64'(idx), 64'd4);
    chk("bp_ready_low_when_full", 64'(s_ready), 64'd0);
    chk("bp_no_pulse_under_hold", 64'(pq.size()), 64'd0);
    chk("bp_outputs_held", 64'(obs()), 64'(37'b0010 << 33));
    hold = 1'b0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      fire = s_ready && s_valid;
      @(posedge clk); #1;
      if (fire) begin idx++; drive_beat(idx); end
    end
    s_valid = 1'b0;
    chk("bp_total_accepts", 64'(idx), 64'd8);
    chk("bp_pulse_count", 64'(pq.size()), 64'd12);
    for (int k = 0; k < 8; k++)
      if (k < pq.size()) chk($sformatf("bp_beat%0d", k), 64'(pq[k]), 64'(beat(k)));
    for (int k = 8; k < 12; k++)
      if (k < pq.size()) chk($sformatf("bp_zero%0d", k), 64'(pq[k]), 64'd0);
    chk("bp_done_once", 64'(done_cnt), 64'd1);

    // Overrun: len=3 with five beats on offer.
    pq.delete(); done_cnt = 0; idx = 0; leak = 0;
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; len = '0;
    for (int c = 0; c < 100 && done_cnt == 0; c++) begin
      s_valid = (idx < 5);
      drive_beat(20 + idx);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      if (idx >= 3 && s_ready) leak++;
    end
    s_valid = 1'b0;
    chk("ovr_accepts", 64'(idx), 64'd3);
    chk("ovr_ready_stays_low", 64'(leak), 64'd0);
    chk("ovr_pulse_count", 64'(pq.size()), 64'd7);
    if (pq.size() > 2) chk("ovr_last_beat", 64'(pq[2]), 64'(beat(22)));
    chk("ovr_done_once", 64'(done_cnt), 64'd1);

    // Reset during FLUSH discards the job.
    pq.delete(); done_cnt = 0;
    start = 1'b1; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; len = '0; s_valid = 1'b1; drive_beat(5);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int c = 0; c < 50 && pq.size() < 2; c++) begin @(negedge clk); #1; end
    chk("rst_reached_flush", 64'(pq.size() >= 2), 64'd1);
    #2 reset = 1'b1;
    #1 chk("rst_outputs_zero", 64'(obs()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("rst_no_done", 64'(done_cnt), 64'd0);

    // Fresh len=1 job after reset, with hold pausing the flush midway.
    pq.delete();
    start = 1'b1; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; len = '0; s_valid = 1'b1; drive_beat(6);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int c = 0; c < 50 && pq.size() < 3; c++) begin @(negedge clk); #1; end
    hold = 1'b1; n = pq.size();
    repeat (3) begin @(negedge clk); #1; end
    chk("flush_hold_pauses", 64'(pq.size()), 64'(n));
    hold = 1'b0;
    for (int c = 0; c < 50 && done_cnt == 0; c++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_pulse_count", 64'(pq.size()), 64'd5);
    if (pq.size() > 0) chk("post_rst_beat", 64'(pq[0]), 64'(beat(6)));
    chk("post_rst_done_once", 64'(done_cnt), 64'd1);
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
